// File: rtl/vote_session_ctrl.sv
// Voter-session arbiter: arm -> grant first unambiguous press -> lockout -> idle; vote_req to vote_grant is 1 cycle.
// No backpressure: requests outside the armed window are dropped, arm is honoured only in IDLE with mode=0.
module vote_session_ctrl #(
  parameter int NUM_CAND    = 4,
  parameter int LOCK_CYCLES = 100,
  parameter int ARM_TIMEOUT = 1000,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                arm,
  input  logic [NUM_CAND-1:0] vote_req,
  output logic [NUM_CAND-1:0] vote_grant,
  output logic                armed,
  output logic                busy,
  output logic                err_multi,
  output logic                err_timeout,
  output logic [CNT_W-1:0]    total_votes
);

  localparam int TO_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam int LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ARM_TIMEOUT - 1);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, GRANT, LOCK} state_t;

  state_t              state, state_nxt;
  logic [TO_W-1:0]     to_cnt, to_cnt_nxt;
  logic [LK_W-1:0]     lk_cnt, lk_cnt_nxt;
  logic [NUM_CAND-1:0] grant_nxt;
  logic                multi_nxt;
  logic                timeout_nxt;
  logic                req_one;
  logic                req_many;

  assign req_one  = (vote_req != '0) && ((vote_req & (vote_req - NUM_CAND'(1))) == '0);
  assign req_many = (vote_req != '0) && !req_one;

  always_comb begin
    state_nxt   = state;
    to_cnt_nxt  = to_cnt;
    lk_cnt_nxt  = lk_cnt;
    grant_nxt   = '0;
    multi_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (arm && !mode) begin
          state_nxt  = ARMED;
          to_cnt_nxt = '0;
        end
      end
      ARMED: begin
        if (mode) begin
          state_nxt = IDLE;
        end else if (req_one) begin
          state_nxt = GRANT;
          grant_nxt = vote_req;
        end else if (req_many) begin
          // An ambiguous press on the final cycle holds the window open one more
          // cycle so err_multi and err_timeout can never pulse together.
          multi_nxt = 1'b1;
          if (to_cnt != TO_LAST) to_cnt_nxt = to_cnt + TO_W'(1);
        end else if (to_cnt == TO_LAST) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      GRANT: begin
        state_nxt  = LOCK;
        lk_cnt_nxt = '0;
      end
      LOCK: begin
        if (lk_cnt == LK_LAST) state_nxt = IDLE;
        else                   lk_cnt_nxt = lk_cnt + LK_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      to_cnt      <= '0;
      lk_cnt      <= '0;
      vote_grant  <= '0;
      armed       <= 1'b0;
      busy        <= 1'b0;
      err_multi   <= 1'b0;
      err_timeout <= 1'b0;
      total_votes <= '0;
    end else begin
      state       <= state_nxt;
      to_cnt      <= to_cnt_nxt;
      lk_cnt      <= lk_cnt_nxt;
      vote_grant  <= grant_nxt;
      armed       <= (state_nxt == ARMED);
      busy        <= (state_nxt == GRANT) || (state_nxt == LOCK);
      err_multi   <= multi_nxt;
      err_timeout <= timeout_nxt;
      if ((state_nxt == GRANT) && (total_votes != '1))
        total_votes <= total_votes + CNT_W'(1);
    end
  end

endmodule
